// File: rtl/sc_posjug1_pkg.sv
// Shared types and constants for the player-1 position writer and its prescaler.
package sc_posjug1_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'b00,
    HIT      = 2'b01,
    GAMEOVER = 2'b10
  } state_e;

  localparam int unsigned POS_WIDTH   = 8;
  localparam int unsigned LANE_LO_BIT = 4;
  localparam int unsigned LANE_HI_BIT = 7;
  localparam int unsigned START_BIT_D = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_posjug1_if.sv
// Button, collision and status bus between the player-1 writer and its environment.
interface sc_posjug1_if #(
  parameter int unsigned DATAWIDTH   = 8,
  parameter int unsigned LIVES_WIDTH = 2
);
  logic                   SC_PosJUG1_left_In;
  logic                   SC_PosJUG1_right_In;
  logic                   SC_PosJUG1_restart_In;
  logic                   SC_PosJUG1_collision_InLow;
  logic [DATAWIDTH-1:0]   SC_PosJUG1_posjug1_OutBUS;
  logic [LIVES_WIDTH-1:0] SC_PosJUG1_lives_OutBUS;
  logic                   SC_PosJUG1_hit_Out;
  logic                   SC_PosJUG1_gameover_Out;

  modport master (
    input  SC_PosJUG1_left_In,
    input  SC_PosJUG1_right_In,
    input  SC_PosJUG1_restart_In,
    input  SC_PosJUG1_collision_InLow,
    output SC_PosJUG1_posjug1_OutBUS,
    output SC_PosJUG1_lives_OutBUS,
    output SC_PosJUG1_hit_Out,
    output SC_PosJUG1_gameover_Out
  );

  modport slave (
    output SC_PosJUG1_left_In,
    output SC_PosJUG1_right_In,
    output SC_PosJUG1_restart_In,
    output SC_PosJUG1_collision_InLow,
    input  SC_PosJUG1_posjug1_OutBUS,
    input  SC_PosJUG1_lives_OutBUS,
    input  SC_PosJUG1_hit_Out,
    input  SC_PosJUG1_gameover_Out
  );
endinterface

// File: rtl/sc_posjug1_tick_prescaler.sv
// Free-running divider emitting a one-cycle tick every PRESCALER_MAX clocks.
module sc_tick_prescaler
  import sc_posjug1_pkg::*;
#(
  parameter int unsigned PRESCALER_MAX = 25000000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = cnt_width(PRESCALER_MAX);
  localparam logic [CW-1:0] LAST = CW'(PRESCALER_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sc_posjug1_writer.sv
// Player-1 position writer: tick-rate-limited moves, lives, post-hit hold, game-over.
// Optional macro SC_POSJUG1_BLINK_EN blanks the position output on alternate HIT ticks.
module sc_posjug1_writer
  import sc_posjug1_pkg::*;
#(
  parameter int unsigned DATAWIDTH     = POS_WIDTH,
  parameter int unsigned LANE_LO       = LANE_LO_BIT,
  parameter int unsigned LANE_HI       = LANE_HI_BIT,
  parameter int unsigned START_BIT     = START_BIT_D,
  parameter int unsigned PRESCALER_MAX = 25000000,
  parameter int unsigned HIT_HOLD      = 4,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned LIVES_WIDTH   = 2
) (
  input  logic         SC_PosJUG1_CLOCK_50,
  input  logic         SC_PosJUG1_RESET_InHigh,
  sc_posjug1_if.master bus
);

  localparam int unsigned HOLD_W = cnt_width(HIT_HOLD);
  localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(HIT_HOLD - 1);
  localparam logic [DATAWIDTH-1:0]   START_POS  = DATAWIDTH'(1) << START_BIT;
  localparam logic [LIVES_WIDTH-1:0] LIVES_INIT = LIVES_WIDTH'(LIVES);

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   pos_q, pos_d;
  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   hit_q, hit_d;
  logic                   tick;
  logic                   hit_exit;
  logic                   mv_left, mv_right;

  sc_tick_prescaler #(
    .PRESCALER_MAX(PRESCALER_MAX)
  ) u_prescaler (
    .clk_i (SC_PosJUG1_CLOCK_50),
    .rst_i (SC_PosJUG1_RESET_InHigh),
    .tick_o(tick)
  );

  assign hit_exit = tick && (hold_q == HOLD_LAST);
  assign mv_left  = bus.SC_PosJUG1_left_In  && !bus.SC_PosJUG1_right_In;
  assign mv_right = bus.SC_PosJUG1_right_In && !bus.SC_PosJUG1_left_In;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    lives_d = lives_q;
    hold_d  = hold_q;
    hit_d   = 1'b0;
    unique case (state_q)
      PLAY: begin
        // Collision wins over a move even on a tick cycle.
        if (!bus.SC_PosJUG1_collision_InLow) begin
          lives_d = (lives_q != '0) ? lives_q - 1'b1 : '0;
          hit_d   = 1'b1;
          hold_d  = '0;
          state_d = HIT;
        end else if (tick) begin
          if (mv_left && !pos_q[LANE_HI])       pos_d = pos_q << 1;
          else if (mv_right && !pos_q[LANE_LO]) pos_d = pos_q >> 1;
        end
      end
      HIT: begin
        if (hit_exit) begin
          if (lives_q == '0) begin
            state_d = GAMEOVER;
          end else begin
            pos_d   = START_POS;
            state_d = PLAY;
          end
        end else if (tick) begin
          hold_d = hold_q + 1'b1;
        end
      end
      GAMEOVER: begin
        if (bus.SC_PosJUG1_restart_In) begin
          lives_d = LIVES_INIT;
          pos_d   = START_POS;
          state_d = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge SC_PosJUG1_CLOCK_50) begin
    if (SC_PosJUG1_RESET_InHigh) begin
      state_q <= PLAY;
      pos_q   <= START_POS;
      lives_q <= LIVES_INIT;
      hold_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      lives_q <= lives_d;
      hold_q  <= hold_d;
      hit_q   <= hit_d;
    end
  end

`ifdef SC_POSJUG1_BLINK_EN
  logic blank_q, blank_d;

  // Blank phase toggles per HIT tick; the leaving tick forces the real position back.
  always_comb begin
    blank_d = 1'b0;
    if (state_q == HIT && tick && !hit_exit) blank_d = ~blank_q;
    else if (state_q == HIT)                 blank_d = blank_q && !hit_exit;
  end

  always_ff @(posedge SC_PosJUG1_CLOCK_50) begin
    if (SC_PosJUG1_RESET_InHigh) blank_q <= 1'b0;
    else                         blank_q <= blank_d;
  end

  assign bus.SC_PosJUG1_posjug1_OutBUS = blank_q ? '0 : pos_q;
`else
  assign bus.SC_PosJUG1_posjug1_OutBUS = pos_q;
`endif

  assign bus.SC_PosJUG1_lives_OutBUS = lives_q;
  assign bus.SC_PosJUG1_hit_Out      = hit_q;
  assign bus.SC_PosJUG1_gameover_Out = (state_q == GAMEOVER);

endmodule

// File: tb/tb_sc_posjug1_writer.sv
// Directed bench for sc_posjug1_writer with a 4-cycle tick, 2-tick hold and 3 lives.
module tb_sc_posjug1_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  sc_posjug1_if #(.DATAWIDTH(8), .LIVES_WIDTH(2)) bus ();

  sc_posjug1_writer #(
    .DATAWIDTH(8), .LANE_LO(4), .LANE_HI(7), .START_BIT(4),
    .PRESCALER_MAX(4), .HIT_HOLD(2), .LIVES(3), .LIVES_WIDTH(2)
  ) dut (
    .SC_PosJUG1_CLOCK_50    (clk),
    .SC_PosJUG1_RESET_InHigh(rst),
    .bus                    (bus)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after each rising edge; cyc counts edges since reset.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic next_tick();
    step(1);
    while (cyc % 4 != 0) step(1);
  endtask

  task automatic idle_inputs();
    bus.SC_PosJUG1_left_In         = 1'b0;
    bus.SC_PosJUG1_right_In        = 1'b0;
    bus.SC_PosJUG1_restart_In      = 1'b0;
    bus.SC_PosJUG1_collision_InLow = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic collide_once();
    bus.SC_PosJUG1_collision_InLow = 1'b0;
    step(1);
    bus.SC_PosJUG1_collision_InLow = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.SC_PosJUG1_posjug1_OutBUS !== 8'h10) begin
      n_fail++; $display("FAIL reset_pos got %h want 10", bus.SC_PosJUG1_posjug1_OutBUS);
    end
    n_checks++;
    if (bus.SC_PosJUG1_lives_OutBUS !== 2'd3) begin
      n_fail++; $display("FAIL reset_lives got %0d want 3", bus.SC_PosJUG1_lives_OutBUS);
    end
    n_checks++;
    if ({bus.SC_PosJUG1_hit_Out, bus.SC_PosJUG1_gameover_Out} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags got %b%b want 00", bus.SC_PosJUG1_hit_Out, bus.SC_PosJUG1_gameover_Out);
    end
  endtask

  task automatic test_move_left();
    logic [7:0] exp_pos [4];
    exp_pos[0] = 8'h20; exp_pos[1] = 8'h40; exp_pos[2] = 8'h80; exp_pos[3] = 8'h80;
    do_reset();
    bus.SC_PosJUG1_left_In = 1'b1;
    step(3);
    n_checks++;
    if (bus.SC_PosJUG1_posjug1_OutBUS !== 8'h10) begin
      n_fail++; $display("FAIL left_pre_tick got %h want 10", bus.SC_PosJUG1_posjug1_OutBUS);
    end
    step(1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(4);
      n_checks++;
      if (bus.SC_PosJUG1_posjug1_OutBUS !== exp_pos[i]) begin
        n_fail++; $display("FAIL left_tick%0d got %h want %h", i, bus.SC_PosJUG1_posjug1_OutBUS, exp_pos[i]);
      end
    end
  endtask

  task automatic test_move_right_both();
    do_reset();
    bus.SC_PosJUG1_left_In = 1'b1;
    step(4);
    bus.SC_PosJUG1_right_In = 1'b1;
    step(20);
    n_checks++;
    if (bus.SC_PosJUG1_posjug1_OutBUS !== 8'h20) begin
      n_fail++; $display("FAIL both_held got %h want 20", bus.SC_PosJUG1_posjug1_OutBUS);
    end
    bus.SC_PosJUG1_left_In = 1'b0;
    step(4);
    n_checks++;
    if (bus.SC_PosJUG1_posjug1_OutBUS !== 8'h10) begin
      n_fail++; $display("FAIL right_step got %h want 10", bus.SC_PosJUG1_posjug1_OutBUS);
    end
    step(4);
    n_checks++;
    if (bus.SC_PosJUG1_posjug1_OutBUS !== 8'h10) begin
      n_fail++; $display("FAIL right_boundary got %h want 10", bus.SC_PosJUG1_posjug1_OutBUS);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_blink;
    do_reset();
    bus.SC_PosJUG1_left_In = 1'b1;
    step(3);
    collide_once();
    n_checks++;
    if ({bus.SC_PosJUG1_hit_Out, bus.SC_PosJUG1_lives_OutBUS, bus.SC_PosJUG1_posjug1_OutBUS} !== {1'b1, 2'd2, 8'h10}) begin
      n_fail++; $display("FAIL hit_detect got hit=%b lives=%0d pos=%h want hit=1 lives=2 pos=10",
                         bus.SC_PosJUG1_hit_Out, bus.SC_PosJUG1_lives_OutBUS, bus.SC_PosJUG1_posjug1_OutBUS);
    end
    step(1);
    n_checks++;
    if ({bus.SC_PosJUG1_hit_Out, bus.SC_PosJUG1_posjug1_OutBUS} !== {1'b0, 8'h10}) begin
      n_fail++; $display("FAIL hit_one_cycle got hit=%b pos=%h want hit=0 pos=10",
                         bus.SC_PosJUG1_hit_Out, bus.SC_PosJUG1_posjug1_OutBUS);
    end
    step(3);
`ifdef SC_POSJUG1_BLINK_EN
    exp_blink = 8'h00;
`else
    exp_blink = 8'h10;
`endif
    n_checks++;
    if (bus.SC_PosJUG1_posjug1_OutBUS !== exp_blink) begin
      n_fail++; $display("FAIL hit_tick1_out got %h want %h", bus.SC_PosJUG1_posjug1_OutBUS, exp_blink);
    end
    step(4);
    n_checks++;
    if ({bus.SC_PosJUG1_posjug1_OutBUS, bus.SC_PosJUG1_gameover_Out} !== {8'h10, 1'b0}) begin
      n_fail++; $display("FAIL respawn got pos=%h go=%b want pos=10 go=0",
                         bus.SC_PosJUG1_posjug1_OutBUS, bus.SC_PosJUG1_gameover_Out);
    end
    step(4);
    n_checks++;
    if (bus.SC_PosJUG1_posjug1_OutBUS !== 8'h20) begin
      n_fail++; $display("FAIL play_after_hit got %h want 20", bus.SC_PosJUG1_posjug1_OutBUS);
    end
  endtask

  task automatic test_gameover();
    do_reset();
    step(1);
    collide_once();
    step(8);
    collide_once();
    n_checks++;
    if (bus.SC_PosJUG1_lives_OutBUS !== 2'd1) begin
      n_fail++; $display("FAIL lives_second got %0d want 1", bus.SC_PosJUG1_lives_OutBUS);
    end
    step(8);
    bus.SC_PosJUG1_left_In = 1'b1;
    next_tick();
    bus.SC_PosJUG1_left_In = 1'b0;
    collide_once();
    step(8);
    n_checks++;
    if ({bus.SC_PosJUG1_gameover_Out, bus.SC_PosJUG1_lives_OutBUS, bus.SC_PosJUG1_posjug1_OutBUS} !== {1'b1, 2'd0, 8'h20}) begin
      n_fail++; $display("FAIL gameover_entry got go=%b lives=%0d pos=%h want go=1 lives=0 pos=20",
                         bus.SC_PosJUG1_gameover_Out, bus.SC_PosJUG1_lives_OutBUS, bus.SC_PosJUG1_posjug1_OutBUS);
    end
    bus.SC_PosJUG1_left_In = 1'b1;
    bus.SC_PosJUG1_collision_InLow = 1'b0;
    step(8);
    n_checks++;
    if ({bus.SC_PosJUG1_gameover_Out, bus.SC_PosJUG1_hit_Out, bus.SC_PosJUG1_lives_OutBUS, bus.SC_PosJUG1_posjug1_OutBUS}
        !== {1'b1, 1'b0, 2'd0, 8'h20}) begin
      n_fail++; $display("FAIL gameover_frozen got go=%b hit=%b lives=%0d pos=%h want go=1 hit=0 lives=0 pos=20",
                         bus.SC_PosJUG1_gameover_Out, bus.SC_PosJUG1_hit_Out, bus.SC_PosJUG1_lives_OutBUS,
                         bus.SC_PosJUG1_posjug1_OutBUS);
    end
    idle_inputs();
    bus.SC_PosJUG1_restart_In = 1'b1;
    step(1);
    bus.SC_PosJUG1_restart_In = 1'b0;
    n_checks++;
    if ({bus.SC_PosJUG1_gameover_Out, bus.SC_PosJUG1_lives_OutBUS, bus.SC_PosJUG1_posjug1_OutBUS} !== {1'b0, 2'd3, 8'h10}) begin
      n_fail++; $display("FAIL restart got go=%b lives=%0d pos=%h want go=0 lives=3 pos=10",
                         bus.SC_PosJUG1_gameover_Out, bus.SC_PosJUG1_lives_OutBUS, bus.SC_PosJUG1_posjug1_OutBUS);
    end
  endtask

  task automatic test_reset_in_hit();
    do_reset();
    step(1);
    collide_once();
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    cyc = 0;
    n_checks++;
    if ({bus.SC_PosJUG1_posjug1_OutBUS, bus.SC_PosJUG1_lives_OutBUS, bus.SC_PosJUG1_hit_Out, bus.SC_PosJUG1_gameover_Out}
        !== {8'h10, 2'd3, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_in_hit got pos=%h lives=%0d hit=%b go=%b want pos=10 lives=3 hit=0 go=0",
                         bus.SC_PosJUG1_posjug1_OutBUS, bus.SC_PosJUG1_lives_OutBUS, bus.SC_PosJUG1_hit_Out,
                         bus.SC_PosJUG1_gameover_Out);
    end
    bus.SC_PosJUG1_left_In = 1'b1;
    step(3);
    n_checks++;
    if (bus.SC_PosJUG1_posjug1_OutBUS !== 8'h10) begin
      n_fail++; $display("FAIL prescaler_restart_early got %h want 10", bus.SC_PosJUG1_posjug1_OutBUS);
    end
    step(1);
    n_checks++;
    if (bus.SC_PosJUG1_posjug1_OutBUS !== 8'h20) begin
      n_fail++; $display("FAIL prescaler_restart_tick got %h want 20", bus.SC_PosJUG1_posjug1_OutBUS);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_move_left();
    test_move_right_both();
    test_collision();
    test_gameover();
    test_reset_in_hit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
